// File: rtl/psum_requant.sv
// Accumulates pairs of signed partial sums over a configurable group length, then
// adds bias, rounds, shifts, optionally applies ReLU, saturates and queues {ch1, ch0}.
module psum_requant #(
    parameter int PSUM_W     = 18,
    parameter int ACC_W      = 26,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_in,
    input  logic [PSUM_W-1:0]   psum0_in,
    input  logic [PSUM_W-1:0]   psum1_in,
    input  logic [7:0]          cfg_acc_len,
    input  logic [4:0]          cfg_shift,
    input  logic                cfg_relu,
    input  logic [23:0]         bias0,
    input  logic [23:0]         bias1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*OUT_W-1:0]  out_data,
    output logic                overflow,
    output logic                busy
);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int SUM_W = ((ACC_W > 24) ? ACC_W : 24) + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = -SUM_W'(2 ** (OUT_W - 1));

    // Accumulation stage: configuration is captured on the opening strobe of a group.
    logic                     r_open;
    logic [7:0]               r_cnt;
    logic [7:0]               r_len;
    logic [4:0]               r_shift;
    logic                     r_relu;
    logic signed [23:0]       r_bias0;
    logic signed [23:0]       r_bias1;
    logic signed [ACC_W-1:0]  r_acc0;
    logic signed [ACC_W-1:0]  r_acc1;
    logic                     r_q1_v;

    logic [7:0]               w_len_in;
    logic                     w_close;
    logic signed [ACC_W-1:0]  w_ps0;
    logic signed [ACC_W-1:0]  w_ps1;

    assign w_len_in = (cfg_acc_len == 8'd0) ? 8'd1 : cfg_acc_len;
    assign w_close  = en_in && (r_open ? ((r_cnt + 8'd1) == r_len) : (w_len_in == 8'd1));
    assign w_ps0    = ACC_W'($signed(psum0_in));
    assign w_ps1    = ACC_W'($signed(psum1_in));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_open  <= 1'b0;
            r_cnt   <= 8'd0;
            r_len   <= 8'd1;
            r_shift <= 5'd0;
            r_relu  <= 1'b0;
            r_bias0 <= '0;
            r_bias1 <= '0;
            r_acc0  <= '0;
            r_acc1  <= '0;
            r_q1_v  <= 1'b0;
        end else begin
            r_q1_v <= w_close;
            if (en_in) begin
                r_open <= !w_close;
                if (!r_open) begin
                    r_cnt   <= 8'd1;
                    r_len   <= w_len_in;
                    r_shift <= cfg_shift;
                    r_relu  <= cfg_relu;
                    r_bias0 <= bias0;
                    r_bias1 <= bias1;
                    r_acc0  <= w_ps0;
                    r_acc1  <= w_ps1;
                end else begin
                    r_cnt  <= r_cnt + 8'd1;
                    r_acc0 <= r_acc0 + w_ps0;
                    r_acc1 <= r_acc1 + w_ps1;
                end
            end
        end
    end

    // Q1: bias and round-half-up constant. Shift/relu travel with the data because a
    // new group may already have reloaded the captured configuration.
    logic signed [SUM_W-1:0] w_rnd;
    logic signed [SUM_W-1:0] w_sum0;
    logic signed [SUM_W-1:0] w_sum1;
    logic signed [SUM_W-1:0] r_sum0;
    logic signed [SUM_W-1:0] r_sum1;
    logic [4:0]              r_q2_shift;
    logic                    r_q2_relu;
    logic                    r_q2_v;

    assign w_rnd  = (r_shift == 5'd0) ? '0 : (SUM_W'(1) << (r_shift - 5'd1));
    assign w_sum0 = SUM_W'(r_acc0) + SUM_W'(r_bias0) + w_rnd;
    assign w_sum1 = SUM_W'(r_acc1) + SUM_W'(r_bias1) + w_rnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum0     <= '0;
            r_sum1     <= '0;
            r_q2_shift <= 5'd0;
            r_q2_relu  <= 1'b0;
            r_q2_v     <= 1'b0;
        end else begin
            r_q2_v <= r_q1_v;
            if (r_q1_v) begin
                r_sum0     <= w_sum0;
                r_sum1     <= w_sum1;
                r_q2_shift <= r_shift;
                r_q2_relu  <= r_relu;
            end
        end
    end

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v, input logic relu);
        if (relu && (v < 0))   return '0;
        else if (v > MAX_V)    return MAX_V[OUT_W-1:0];
        else if (v < MIN_V)    return MIN_V[OUT_W-1:0];
        else                   return v[OUT_W-1:0];
    endfunction

    // Q2: shift and clamp feed the FIFO write directly.
    logic signed [SUM_W-1:0] w_shr0;
    logic signed [SUM_W-1:0] w_shr1;
    logic [2*OUT_W-1:0]      w_q2_data;

    assign w_shr0    = r_sum0 >>> r_q2_shift;
    assign w_shr1    = r_sum1 >>> r_q2_shift;
    assign w_q2_data = {sat_out(w_shr1, r_q2_relu), sat_out(w_shr0, r_q2_relu)};

    // Output FIFO: a full write is still accepted when the head leaves the same cycle.
    logic [2*OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic               w_rd;
    logic               w_full;
    logic               w_wr;

    assign w_rd   = out_valid && out_ready;
    assign w_full = (r_count == DEPTH_C);
    assign w_wr   = r_q2_v && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_q2_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
            if (r_q2_v && !w_wr) r_ovf <= 1'b1;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rptr] : '0;
    assign overflow  = r_ovf;
    assign busy      = r_open || r_q1_v || r_q2_v;
endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant: hand-computed vectors for rounding, relu, saturation,
// group boundaries, reset mid-group and FIFO overflow/ordering.
module tb_psum_requant;
    localparam int PSUM_W = 18;
    localparam int OUT_W  = 8;

    logic                clk;
    logic                rst;
    logic                en_in;
    logic [PSUM_W-1:0]   psum0_in;
    logic [PSUM_W-1:0]   psum1_in;
    logic [7:0]          cfg_acc_len;
    logic [4:0]          cfg_shift;
    logic                cfg_relu;
    logic [23:0]         bias0;
    logic [23:0]         bias1;
    logic                out_valid;
    logic                out_ready;
    logic [2*OUT_W-1:0]  out_data;
    logic                overflow;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

    psum_requant #(.PSUM_W(PSUM_W), .ACC_W(26), .OUT_W(OUT_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en_in(en_in), .psum0_in(psum0_in), .psum1_in(psum1_in),
        .cfg_acc_len(cfg_acc_len), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .bias0(bias0), .bias1(bias1), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow(overflow), .busy(busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: all inputs change on the falling edge, outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int p0, input int p1);
        @(negedge clk);
        en_in    = 1'b1;
        psum0_in = p0[PSUM_W-1:0];
        psum1_in = p1[PSUM_W-1:0];
    endtask

    task automatic idle();
        @(negedge clk);
        en_in    = 1'b0;
        psum0_in = '0;
        psum1_in = '0;
    endtask

    task automatic set_cfg(input int len, input int sh, input logic relu, input int b0, input int b1);
        cfg_acc_len = len[7:0];
        cfg_shift   = sh[4:0];
        cfg_relu    = relu;
        bias0       = b0[23:0];
        bias1       = b1[23:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        en_in = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_in = 1'b0; psum0_in = '0; psum1_in = '0; out_ready = 1'b0;
        set_cfg(1, 0, 1'b0, 0, 0);
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Rounding + bias; cfg changed mid-group must not matter.
        set_cfg(4, 2, 1'b0, -16, 0);
        strobe(100, -50);
        check("open_busy", 32'(busy), 32'd0);
        strobe(100, -50);
        set_cfg(1, 0, 1'b1, 0, 0);
        strobe(100, -50);
        strobe(100, -50);
        idle();
        check("q1_busy", 32'(busy), 32'd1);
        tick(1);
        check("t2_valid", 32'(out_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        tick(1);
        check("t3_busy", 32'(busy), 32'd0);
        pop_check("basic", 16'hCE60);
        check("basic_empty", 32'(out_valid), 32'd0);

        // Same group with relu.
        set_cfg(4, 2, 1'b1, -16, 0);
        repeat (4) strobe(100, -50);
        idle();
        tick(2);
        pop_check("relu", 16'h0060);

        // Saturation at both ends; no overflow from saturation.
        set_cfg(1, 0, 1'b0, 0, 0);
        strobe(131071, -131072);
        idle();
        tick(2);
        check("sat_ovf", 32'(overflow), 32'd0);
        pop_check("sat", 16'h807F);

        // acc_len 0 behaves as 1.
        set_cfg(0, 0, 1'b0, 0, 0);
        strobe(5, 3);
        idle();
        tick(2);
        pop_check("len0", 16'h0305);

        // Back-to-back groups of 3.
        set_cfg(3, 0, 1'b0, 0, 0);
        repeat (3) strobe(1, 0);
        repeat (3) strobe(2, 0);
        idle();
        tick(2);
        pop_check("b2b_first", 16'h0003);
        pop_check("b2b_second", 16'h0006);
        check("b2b_empty", 32'(out_valid), 32'd0);

        // Reset in the middle of a group.
        set_cfg(4, 0, 1'b0, 0, 0);
        strobe(7, 7);
        strobe(7, 7);
        do_reset();
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (4) strobe(10, 0);
        idle();
        tick(2);
        pop_check("midrst", 16'h0028);
        check("midrst_empty", 32'(out_valid), 32'd0);

        // Overflow: five single-strobe groups into a four-entry FIFO.
        set_cfg(1, 0, 1'b0, 0, 0);
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) strobe(k, 0);
        idle();
        tick(3);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_v%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("ovf_d%0d", k), 32'(out_data), 32'(k));
            @(negedge clk);
        end
        check("ovf_drained", 32'(out_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/psum_requant.md
PSUM_REQUANT -- requirements
Module: psum_requant

Interface
REQ-001 SHALL have parameter PSUM_W, default 18: width of each incoming partial sum.
REQ-002 SHALL have parameter ACC_W, default 26: internal accumulator width (PSUM_W + 8).
REQ-003 SHALL have parameter OUT_W, default 8: width of each requantized output channel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries (power of two).
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en_in  in  1  single-cycle strobe; psum0_in/psum1_in valid this cycle.
REQ-008 psum0_in  in  PSUM_W  signed partial sum, channel 0.
REQ-009 psum1_in  in  PSUM_W  signed partial sum, channel 1.
REQ-010 cfg_acc_len  in  8  en_in strobes per output group; 0 treated as 1.
REQ-011 cfg_shift  in  5  arithmetic right-shift amount, 0..24.
REQ-012 cfg_relu  in  1  1 = clamp negative results to 0.
REQ-013 bias0/bias1  in  24 each  signed per-channel bias.
REQ-014 out_valid  out  1  FIFO not empty.
REQ-015 out_ready  in  1  downstream accepts out_data when out_valid=1.
REQ-016 out_data  out  2*OUT_W  {ch1, ch0} signed results, FIFO head.
REQ-017 overflow  out  1  sticky; result dropped because FIFO was full.
REQ-018 busy  out  1  group open or requant pipeline occupied.

Function
REQ-019 SHALL sample cfg_acc_len, cfg_shift, cfg_relu, bias0, bias1 on the first en_in of a group; changes mid-group SHALL have no effect until the next group.
REQ-020 SHALL sign-extend each psum to ACC_W and add it to its channel accumulator on every en_in; the first en_in of a group SHALL load, not add.
REQ-021 SHALL count en_in strobes; strobe number cfg_acc_len SHALL close the group, so the next en_in (even in the following cycle) starts a new group with no lost strobe.
REQ-022 Stage Q1 (cycle after close): acc + sign-extended bias + rounding constant (1<<(shift-1) if shift>0, else 0).
REQ-023 Stage Q2: arithmetic right shift by shift; with relu, negatives become 0; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; write {ch1,ch0} into FIFO.
REQ-024 Latency: last en_in of group at cycle T -> entry written at T+3, out_valid high at T+3 if FIFO was empty.
REQ-025 FIFO read SHALL occur when out_valid && out_ready; order SHALL be first-in first-out.
REQ-026 Write when full with no same-cycle read SHALL drop the entry and set overflow; write when full with same-cycle read SHALL be accepted.
REQ-027 overflow SHALL clear only on rst; saturation SHALL NOT set overflow.
REQ-028 Read with FIFO empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-029 busy SHALL be high from first en_in of a group until the Q2 write cycle inclusive.

Reset
REQ-030 On rst: accumulators, strobe counter, Q1/Q2 stages, FIFO pointers and occupancy cleared; out_valid=0, out_data=0, overflow=0, busy=0.
REQ-031 rst mid-group or mid-pipeline SHALL discard the partial group; first en_in after rst starts a new group.

Verification
REQ-032 acc_len=4, shift=2, relu=0, bias0=-16, bias1=0, 4x psum0=100, psum1=-50 -> out_data=0xCE60 at T+3.
REQ-033 Same stimulus with relu=1 -> out_data=0x0060.
REQ-034 acc_len=1, shift=0, psum0=131071, psum1=-131072 -> out_data=0x807F, overflow=0.
REQ-035 out_ready=0, acc_len=1, 5 groups of values 1..5 -> 5th dropped, overflow=1; then out_ready=1 -> entries 1,2,3,4 in order, then out_valid=0.
REQ-036 acc_len=3, two back-to-back groups of 3 contiguous en_in (psum0=1 then 2, shift=0) -> outputs 3 then 6, no strobe lost.
REQ-037 rst asserted after 2 of 4 strobes, then 4 strobes psum0=10 -> single output ch0=40, no stale contribution.
